// File: rtl/gesture_display_pkg.sv
// gesture_display_pkg: shared constants, mode encodings and the gesture word table
package gesture_display_pkg;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int MAX_WORD = 16;
    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;
    typedef struct packed {
        logic valid;
        logic [MAX_WORD-1:0][7:0] chars;
    } word_t;
    // Literals are exactly MAX_WORD characters so the first letter lands in chars[0].
    function automatic word_t gesture_word(input logic [3:0] code);
        word_t r;
        logic [8*MAX_WORD-1:0] txt;
        r.valid = 1'b1;
        case (code)
            4'd0: txt = "                ";
            4'd1: txt = "HELLO           ";
            4'd2: txt = "UP              ";
            4'd3: txt = "OPEN            ";
            4'd4: txt = "HOLD            ";
            default: begin
                txt = "                ";
                r.valid = 1'b0;
            end
        endcase
        for (int i = 0; i < MAX_WORD; i++) r.chars[i] = txt[8*(MAX_WORD-1-i) +: 8];
        return r;
    endfunction
endpackage

// File: rtl/char_to_7seg.sv
// char_to_7seg: ASCII character to active-low seven-segment pattern (bit 0 = segment a)
module char_to_7seg
    import gesture_display_pkg::*;
(
    input  logic [7:0] ch,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (ch)
            "0", "O": seg = 7'h40;
            "1": seg = 7'h79;
            "2": seg = 7'h24;
            "3": seg = 7'h30;
            "4": seg = 7'h19;
            "5": seg = 7'h12;
            "6": seg = 7'h02;
            "7": seg = 7'h78;
            "8": seg = 7'h00;
            "9": seg = 7'h10;
            "A": seg = 7'h08;
            "C": seg = 7'h46;
            "D": seg = 7'h21;
            "E": seg = 7'h06;
            "F": seg = 7'h0E;
            "H": seg = 7'h09;
            "L": seg = 7'h47;
            "N": seg = 7'h2B;
            "P": seg = 7'h0C;
            "U": seg = 7'h41;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/gesture_scroll_ctrl.sv
// gesture_scroll_ctrl: display tick divider, scroll position, blink phase and wrap pulse
module gesture_scroll_ctrl
    import gesture_display_pkg::*;
#(
    parameter int MSG_LEN = 16,
    parameter int TICK_DIV = 12_500_000,
    parameter int PW = $clog2(MSG_LEN) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [1:0]    mode,
    output logic [PW-1:0] pos,
    output logic          hidden,
    output logic          wrap
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt;
    logic [1:0] mode_q;
    logic tick, last;
    assign tick = cnt == CW'(TICK_DIV - 1);
    assign last = pos == PW'(MSG_LEN - 1);
    // Load and mode change both restart the display and swallow a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pos <= '0;
            hidden <= 1'b0;
            wrap <= 1'b0;
            mode_q <= MODE_STATIC;
        end else begin
            mode_q <= mode;
            wrap <= 1'b0;
            if (load || mode != mode_q) begin
                cnt <= '0;
                pos <= '0;
                hidden <= 1'b0;
            end else begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick && mode == MODE_SCROLL) begin
                    pos <= last ? '0 : pos + 1'b1;
                    wrap <= last;
                end
                if (tick && mode == MODE_BLINK) hidden <= !hidden;
            end
        end
    end
endmodule

// File: rtl/gesture_scroll_display.sv
// gesture_scroll_display: latches a gesture code and shows its word on NUM_DIGITS seven-segment digits
module gesture_scroll_display
    import gesture_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN = 16,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              gesture_code,
    input  logic                    gesture_valid,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    wrap,
    output logic                    unknown
);
    localparam int AW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1;
    localparam int PW = $clog2(MSG_LEN) + 1;
    logic [3:0] code_q;
    word_t wq;
    logic [7:0] msg [MSG_LEN];
    logic [PW-1:0] pos;
    logic hidden;
    logic [7*NUM_DIGITS-1:0] seg_d;
    always_ff @(posedge clk) begin
        if (rst) code_q <= 4'd0;
        else if (gesture_valid) code_q <= gesture_code;
    end
    // The buffer is the table entry of the latched code, so it reloads on every strobe.
    assign wq = gesture_word(code_q);
    assign unknown = !wq.valid;
    always_comb begin
        for (int i = 0; i < MSG_LEN; i++) msg[i] = i < MAX_WORD ? wq.chars[i % MAX_WORD] : CHAR_SPACE;
    end
    gesture_scroll_ctrl #(.MSG_LEN(MSG_LEN), .TICK_DIV(TICK_DIV), .PW(PW)) u_ctrl (
        .clk(clk),
        .rst(rst),
        .load(gesture_valid),
        .mode(mode),
        .pos(pos),
        .hidden(hidden),
        .wrap(wrap)
    );
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        logic [PW-1:0] idx;
        assign idx = (pos + PW'(NUM_DIGITS - 1 - k)) % PW'(MSG_LEN);
        char_to_7seg u_dec (.ch(msg[idx[AW-1:0]]), .seg(seg_d[7*k +: 7]));
    end
    always_ff @(posedge clk) begin
        if (rst || hidden) seg <= {NUM_DIGITS{SEG_BLANK}};
        else seg <= seg_d;
    end
endmodule

// File: tb/tb_gesture_scroll_display.sv
// tb_gesture_scroll_display: directed and random checks against a behavioural display model
module tb_gesture_scroll_display;
    localparam int ND = 6;
    localparam int ML = 8;
    localparam int TD = 4;
    localparam logic [41:0] BLANK = {6{7'h7F}};
    localparam logic [41:0] HELLO = {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F};
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] gesture_code = 4'd0;
    logic gesture_valid = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [41:0] seg;
    logic wrap, unknown;
    int checks = 0;
    int failures = 0;
    byte m_msg [ML];
    int m_code, m_pos, m_cnt, m_mode_q;
    bit m_hidden, m_wrap;
    logic [41:0] exp_seg;
    gesture_scroll_display #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
        .clk(clk),
        .rst(rst),
        .gesture_code(gesture_code),
        .gesture_valid(gesture_valid),
        .mode(mode),
        .seg(seg),
        .wrap(wrap),
        .unknown(unknown)
    );
    always #5 clk = !clk;
    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "H": return 7'h09;
            "E": return 7'h06;
            "L": return 7'h47;
            "O": return 7'h40;
            default: return 7'h7F;
        endcase
    endfunction
    function automatic byte word_char(input int code, input int i);
        string s;
        s = "HELLO";
        return (code == 1 && i < s.len()) ? s[i] : 8'h20;
    endfunction
    task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask
    task automatic cyc(input bit v, input int c, input int md, input bit r);
        logic [41:0] nxt;
        rst = r;
        gesture_valid = v;
        gesture_code = 4'(c);
        mode = 2'(md);
        @(posedge clk);
        for (int k = 0; k < ND; k++)
            nxt[7*k +: 7] = m_hidden ? 7'h7F : seg_of(m_msg[(m_pos + ND - 1 - k) % ML]);
        exp_seg = r ? BLANK : nxt;
        if (r) begin
            m_code = 0; m_pos = 0; m_cnt = 0; m_hidden = 0; m_mode_q = 0; m_wrap = 0;
            foreach (m_msg[i]) m_msg[i] = 8'h20;
        end else begin
            m_wrap = 0;
            if (v) begin
                m_code = c; m_pos = 0; m_cnt = 0; m_hidden = 0;
                foreach (m_msg[i]) m_msg[i] = word_char(c, i);
            end else if (md != m_mode_q) begin
                m_pos = 0; m_cnt = 0; m_hidden = 0;
            end else if (m_cnt == TD - 1) begin
                m_cnt = 0;
                if (md == 1) begin
                    m_pos = (m_pos + 1) % ML;
                    m_wrap = m_pos == 0;
                end
                if (md == 2) m_hidden = !m_hidden;
            end else m_cnt++;
            m_mode_q = md;
        end
        #1;
        chk("model_seg", seg, exp_seg);
        checks++;
        assert (wrap === m_wrap) else begin
            failures++;
            $error("FAIL model_wrap observed=%b expected=%b", wrap, m_wrap);
        end
        checks++;
        assert (unknown === !(m_code inside {0, 1})) else begin
            failures++;
            $error("FAIL model_unknown observed=%b expected=%b", unknown, !(m_code inside {0, 1}));
        end
    endtask
    initial begin
        int nw, we, c;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        chk("reset_seg", seg, BLANK);
        chk("reset_wrap", {41'd0, wrap}, 42'd0);
        chk("reset_unknown", {41'd0, unknown}, 42'd0);
        cyc(1, 1, 0, 0);
        chk("static_latency1", seg, BLANK);
        cyc(0, 0, 0, 0);
        chk("static_hello", seg, HELLO);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
        chk("static_hold", seg, HELLO);
        cyc(1, 1, 1, 0);
        nw = 0;
        we = -1;
        for (int e = 1; e <= 40; e++) begin
            cyc(0, 0, 1, 0);
            if (e == 4) chk("scroll_pre_tick", {35'd0, seg[41:35]}, 42'h09);
            if (e == 5) chk("scroll_one_tick", {35'd0, seg[41:35]}, 42'h06);
            if (e == 13) chk("scroll_window_wrap", {35'd0, seg[6:0]}, 42'h09);
            if (wrap) begin
                nw++;
                we = e;
            end
        end
        chk("wrap_count", 42'(nw), 42'd1);
        chk("wrap_cycle", 42'(we), 42'd32);
        cyc(1, 1, 2, 0);
        for (int e = 1; e <= 20; e++) begin
            cyc(e == 12, 1, 2, 0);
            if (e == 2) chk("blink_vis", seg, HELLO);
            if (e == 6) chk("blink_hid", seg, BLANK);
            if (e == 10) chk("blink_vis2", seg, HELLO);
            if (e == 13) chk("blink_load_on_tick", seg, HELLO);
            if (e == 17) chk("blink_after_reload", seg, BLANK);
        end
        cyc(1, 15, 0, 0);
        chk("unknown_set", {41'd0, unknown}, 42'd1);
        cyc(0, 0, 0, 0);
        chk("unknown_blank", seg, BLANK);
        cyc(1, 1, 0, 0);
        chk("unknown_clear", {41'd0, unknown}, 42'd0);
        cyc(0, 0, 0, 0);
        chk("unknown_hello", seg, HELLO);
        cyc(1, 1, 1, 0);
        for (int e = 0; e < 12; e++) cyc(0, 0, 1, 0);
        chk("midscroll_pos3", {35'd0, seg[41:35]}, 42'h47);
        cyc(0, 0, 1, 1);
        chk("midscroll_reset", seg, BLANK);
        cyc(1, 1, 1, 0);
        for (int e = 0; e < 9; e++) cyc(0, 0, 1, 0);
        chk("scroll_pos2", {35'd0, seg[41:35]}, 42'h47);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("mode_switch_pos0", seg, HELLO);
        cyc(0, 0, 1, 0);
        for (int e = 1; e <= 5; e++) begin
            cyc(0, 0, 1, 0);
            if (e == 4) chk("cnt_restart_hold", {35'd0, seg[41:35]}, 42'h09);
            if (e == 5) chk("cnt_restart_shift", {35'd0, seg[41:35]}, 42'h06);
        end
        for (int i = 0; i < 400; i++) begin
            c = $urandom_range(0, 9);
            cyc($urandom_range(0, 15) == 0, c < 2 ? c : c + 6,
                ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, 3)) : int'(mode),
                $urandom_range(0, 99) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gesture_scroll_display.md
# gesture_scroll_display

Parametrised gesture-to-seven-segment word display, successor to the fixed six-digit static decoder. It latches a gesture code and loads that code's word into a MSG_LEN-character buffer. The buffer drives NUM_DIGITS seven-segment digits in one of three modes: static, scrolling marquee or blinking. It sits between the gesture classifier and the board HEX outputs. Each digit is rendered through the existing per-character seven-segment decoder.

## Interface
- NUM_DIGITS, 6: number of seven-segment digits driven; ≥1.
- MSG_LEN, 16: message buffer length in characters; ≥ NUM_DIGITS.
- TICK_DIV, 12_500_000: clock cycles per display tick (4 Hz at 50 MHz); ≥2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- gesture_code  in  4  gesture to display; sampled only when gesture_valid=1.
- gesture_valid  in  1  single-cycle load strobe.
- mode  in  2  0=static, 1=scroll, 2=blink, 3=reserved (behaves as static).
- seg  out  7*NUM_DIGITS  segment patterns, active-low. Digit k occupies seg[7k+6:7k]; digit 0 is rightmost (HEX0).
- wrap  out  1  one-cycle pulse when the scroll position wraps MSG_LEN-1→0.
- unknown  out  1  level; 1 while the latched code has no table entry.

## Operation
- Message buffer: MSG_LEN 8-bit ASCII chars, index 0 = leftmost. It is loaded from the package table entry for the latched code, left-aligned and space-padded. Unknown codes load all spaces and set unknown=1.
- Load: gesture_valid=1 → latch code, reload buffer, pos←0, tick counter←0, blink phase←visible. A load repeats even when the code is unchanged.
- Tick: counter counts 0..TICK_DIV-1; tick asserts on the cycle the counter equals TICK_DIV-1.
- Static (mode 0/3): pos held at 0; all digits visible.
- Scroll (mode 1): on each tick, pos←pos+1, with pos=MSG_LEN-1 → 0 and wrap=1 for that cycle.
- Blink (mode 2): pos held at 0; blink phase toggles on each tick; hidden phase → every digit blank (7'h7F).
- Digit mapping: digit k shows buf[(pos + NUM_DIGITS-1-k) mod MSG_LEN]. Index arithmetic is width $clog2(MSG_LEN)+1 with explicit modulo; no reliance on power-of-two MSG_LEN.
- Mode change, detected by comparing mode with its registered copy: pos←0, counter←0, phase←visible, on the cycle after the change is seen.
- Priority: rst > gesture_valid > mode change > tick. A tick coinciding with load or mode change is discarded.

## Timing
- Reset values:
  - seg=all 7'h7F (blank); wrap=0; unknown=0.
  - latched code=0; buffer all spaces; pos=0; counter=0; phase=visible; registered mode=0.
- Reset mid-scroll aborts immediately; the next cycle shows blank.
- seg is registered.
  - Load strobe at edge N → buffer updated at edge N → seg reflects new word after edge N+1 (2-cycle latency from strobe).
  - The same 2-cycle latency applies from tick to visible shift or blink change.
- wrap is registered and asserted in the same cycle pos becomes 0.
- unknown updates together with the buffer at edge N.

## Structure
- Package gesture_display_pkg:
  - CHAR_SPACE=8'h20, SEG_BLANK=7'h7F, mode encodings.
  - MAX_WORD=16.
  - gesture word table as a function gesture_word(code) returning chars plus a valid bit. Entries: 0→spaces, 1→"HELLO", further entries owned by the table.
- Sub-module: gesture_scroll_ctrl holds the tick counter, pos and blink phase, plus the wrap logic.
- Top instantiates NUM_DIGITS copies of the existing char_to_7seg via generate, followed by the output register.

## Test plan
Parameters for all tests: NUM_DIGITS=6, MSG_LEN=8, TICK_DIV=4.
- Reset held 3 cycles → seg all 7'h7F, wrap=0, unknown=0.
- Mode 0, load code 1 → two edges later digits 5..0 show "HELLO " (patterns for H,E,L,L,O,blank); unchanged after 20 cycles.
- Mode 1, load code 1:
  - After 1 tick, digit 5 shows 'E'.
  - After 8 ticks, pos back to 0 with a single-cycle wrap pulse.
  - Digit 0 on that pass shows buf[(pos+5) mod 8], checking wrap-around of the window.
- Mode 2, load code 1 → display alternates "HELLO " and all-blank every 4 cycles. A load on a tick cycle restarts in the visible phase with the counter at 0.
- Load code 4'hF (unmapped) → unknown=1 and all-blank. A following load of code 1 → unknown=0, "HELLO ".
- rst asserted mid-scroll at pos=3 → next cycle all blank and pos=0. Mode switch 1→0 mid-scroll → pos=0, counter restarts.
